// File: rtl/param_seq_det.sv
// Runtime-programmable serial sequence detector: valid-qualified input,
// selectable overlapping matches and a saturating match counter.
module param_seq_det #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               serIn,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               w,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);
  // state | meaning
  // IDLE  | no legal config latched; input ignored
  // ARMED | legal config latched; shifting valid bits and matching
  typedef enum logic {IDLE, ARMED} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d, hist_q, hist_d, new_hist, len_mask;
  logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d, new_fill;
  logic               ovl_q, ovl_d, w_d, err_d, hit;
  logic [CNT_W-1:0]   cnt_d;

  // Only the low len bits of history take part in the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
    new_hist = (hist_q << 1) | MAX_LEN'(serIn);
    new_fill = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);
    hit      = ((new_hist & len_mask) == (pat_q & len_mask)) && (new_fill >= len_q);
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    w_d     = 1'b0;
    cnt_d   = match_cnt;
    err_d   = cfg_err;
    if (cfg_load) begin
      pat_d   = cfg_pattern;
      len_d   = cfg_len;
      ovl_d   = cfg_overlap;
      err_d   = (cfg_len < LEN_MIN) || (cfg_len > LEN_MAX);
      hist_d  = '0;
      fill_d  = '0;
      state_d = err_d ? IDLE : ARMED;
    end else begin
      case (state_q)
        ARMED: begin
          if (in_valid) begin
            hist_d = new_hist;
            fill_d = new_fill;
            if (hit) begin
              w_d = 1'b1;
              if (match_cnt != '1) cnt_d = match_cnt + CNT_W'(1);
              // Non-overlapping: next match must be built from fresh bits.
              if (!ovl_q) fill_d = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      w         <= 1'b0;
      match_cnt <= '0;
      cfg_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      w         <= w_d;
      match_cnt <= cnt_d;
      cfg_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_param_seq_det.sv
// Bench for param_seq_det: bit-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_param_seq_det;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               serIn = 1'b0;
  logic               in_valid = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               w;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;

  int total = 0;
  int bad = 0;
  int wpulses = 0;

  always #5 clk = ~clk;

  param_seq_det #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .serIn(serIn), .in_valid(in_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .w(w), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );

  // Reference model: the sampled bits since the last clear, newest at the back.
  bit                 m_w = 0;
  int                 m_cnt = 0;
  bit                 m_err = 0;
  bit                 m_armed = 0;
  logic [MAX_LEN-1:0] m_pat = '0;
  int                 m_len = 0;
  bit                 m_ovl = 0;
  bit                 q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_w = 0; m_cnt = 0; m_err = 0; m_armed = 0;
      m_pat = '0; m_len = 0; m_ovl = 0;
      q.delete();
    end else if (cfg_load) begin
      m_pat   = cfg_pattern;
      m_len   = int'(cfg_len);
      m_ovl   = cfg_overlap;
      m_err   = (m_len < 2) || (m_len > MAX_LEN);
      m_armed = !m_err;
      m_w     = 0;
      q.delete();
    end else begin
      m_w = 0;
      if (m_armed && in_valid) begin
        bit h;
        q.push_back(serIn);
        if (q.size() > MAX_LEN) void'(q.pop_front());
        h = (q.size() >= m_len);
        if (h) begin
          for (int i = 0; i < m_len; i++)
            if (q[q.size() - 1 - i] != m_pat[i]) h = 0;
        end
        if (h) begin
          m_w = 1;
          if (m_cnt < CNT_MAX) m_cnt++;
          if (!m_ovl) q.delete();
        end
      end
    end
  end

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("w_vs_model", w, m_w);
    chk("cnt_vs_model", match_cnt, m_cnt);
    chk("err_vs_model", cfg_err, m_err);
    if (w === 1'b1) wpulses++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(logic [MAX_LEN-1:0] p, int l, bit o);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = LEN_W'(l);
    cfg_overlap = o;
    in_valid    = 1'b1;
    serIn       = 1'($urandom_range(0, 1));
    cyc();
    cfg_load = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send(bit b, bit v);
    serIn    = b;
    in_valid = v;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic rand_load();
    int l;
    if ($urandom_range(0, 9) == 0) l = $urandom_range(0, 15);
    else l = $urandom_range(2, MAX_LEN);
    load(MAX_LEN'($urandom), l, 1'($urandom_range(0, 1)));
  endtask

  bit s1[13] = '{0, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0};
  bit s3[5]  = '{1, 0, 1, 0, 1};

  initial begin
    int wp0;
    #1 rst = 1'b0;
    cyc();
    chk("reset_w", w, 0);
    chk("reset_cnt", match_cnt, 0);
    chk("reset_err", cfg_err, 0);
    rst = 1'b1;

    // Overlapping 7-bit flag: shared 0 starts the second match.
    load(8'b0111110, 7, 1);
    wp0 = wpulses;
    for (int i = 0; i < 13; i++) begin
      send(s1[i], 1);
      chk("ovl_w_bit", w, (i == 6 || i == 12) ? 1 : 0);
    end
    cyc();
    chk("ovl_pulses", wpulses - wp0, 2);
    chk("ovl_cnt", match_cnt, 2);

    pulse_rst();
    load(8'b0111110, 7, 0);
    wp0 = wpulses;
    for (int i = 0; i < 13; i++) begin
      send(s1[i], 1);
      chk("novl_w_bit", w, (i == 6) ? 1 : 0);
    end
    cyc();
    chk("novl_pulses", wpulses - wp0, 1);
    chk("novl_cnt", match_cnt, 1);

    // Gapped valid: only sampled bits count, gaps never pulse.
    load(8'b101, 3, 1);
    for (int i = 0; i < 5; i++) begin
      send(s3[i], 1);
      chk("gap_w_bit", w, (i == 2 || i == 4) ? 1 : 0);
      send(1'($urandom_range(0, 1)), 0);
      chk("gap_w_idle", w, 0);
    end

    // Illegal lengths at both ends.
    load(8'hFF, 1, 1);
    chk("err_len1", cfg_err, 1);
    wp0 = wpulses;
    for (int i = 0; i < 12; i++) send(1'($urandom_range(0, 1)), 1);
    load(8'hFF, MAX_LEN + 1, 1);
    chk("err_lenmax1", cfg_err, 1);
    for (int i = 0; i < 12; i++) send(1'b1, 1);
    cyc();
    chk("err_no_pulse", wpulses - wp0, 0);
    load(8'b1010, 4, 0);
    chk("err_clear", cfg_err, 0);
    load(8'hA5, MAX_LEN, 1);
    chk("err_lenmax", cfg_err, 0);

    // Counter saturation; w keeps pulsing.
    pulse_rst();
    load(8'b11, 2, 1);
    wp0 = wpulses;
    for (int i = 0; i < 300; i++) send(1'b1, 1);
    chk("sat_w", w, 1);
    cyc();
    chk("sat_cnt", match_cnt, CNT_MAX);
    chk("sat_pulses", wpulses - wp0, 299);

    // Asynchronous reset in the middle of a pattern.
    pulse_rst();
    load(8'b0111110, 7, 1);
    for (int i = 0; i < 7; i++) send(s1[i], 1);
    for (int i = 0; i < 5; i++) send(s1[i], 1);
    chk("pre_rst_cnt", match_cnt, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_w", w, 0);
    chk("async_cnt", match_cnt, 0);
    chk("async_err", cfg_err, 0);
    rst = 1'b1;
    wp0 = wpulses;
    for (int i = 0; i < 13; i++) send(s1[i], 1);
    cyc();
    chk("post_rst_pulses", wpulses - wp0, 0);
    chk("post_rst_cnt", match_cnt, 0);

    // Randomized traffic with occasional mid-stream reconfiguration.
    for (int r = 0; r < 25; r++) begin
      rand_load();
      for (int c = 0; c < 120; c++) begin
        if ($urandom_range(0, 59) == 0) rand_load();
        else send(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      end
    end
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_seq_det.md
Name: param_seq_det

Overview:
- Parametrised, runtime-programmable serial sequence detector; successor to the fixed 7-bit flag detector in the serial receive path.
- Pattern and length are loaded at runtime, up to MAX_LEN bits.
- Overlapping or non-overlapping match mode is selectable.
- Input is qualified by a valid strobe; a saturating match counter is kept for status readout.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits; legal range is 2 or more.
- CNT_W, 8, width of the match counter.
- LEN_W, $clog2(MAX_LEN+1), width of the length field (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- serIn  input  1  serial data bit.
- in_valid  input  1  serIn is sampled only on edges where this is 1.
- cfg_load  input  1  latch the cfg_* inputs; one-cycle strobe.
- cfg_pattern  input  MAX_LEN  pattern bits; bit [cfg_len-1] is the first bit received, bit [0] the last.
- cfg_len  input  LEN_W  pattern length.
- cfg_overlap  input  1  1 = overlapping matches allowed.
- w  output  1  one-cycle match pulse.
- match_cnt  output  CNT_W  saturating count of matches.
- cfg_err  output  1  latched configuration is illegal.

Behaviour:
- Reset (rst=0, asynchronous):
  - Registered config cleared: pattern=0, len=0, overlap=0.
  - History hist=0, fill=0, state=IDLE.
  - Outputs: w=0, match_cnt=0, cfg_err=0.
- Config is registered internally and changes only on cfg_load.
- cfg_load edge:
  - Latch pattern, len and overlap.
  - cfg_err <= (cfg_len<2 || cfg_len>MAX_LEN).
  - Clear hist and fill; w=0 on that edge.
  - match_cnt is not cleared.
  - Next state is ARMED if the config is legal, else IDLE.
  - cfg_load has priority over in_valid on the same edge; that serIn bit is discarded.
- FSM states:
  - IDLE: ignores in_valid; w=0.
  - ARMED: on an edge with in_valid=1:
    - hist <= {hist[MAX_LEN-2:0], serIn}.
    - fill <= min(fill+1, MAX_LEN).
  - ARMED match check: new_hist[len-1:0]==pattern[len-1:0] and new fill >= len.
  - On a match, on the same edge:
    - w <= 1 (visible for exactly one cycle after the sampling edge; latency 1).
    - match_cnt <= match_cnt+1, saturating at all ones.
    - If overlap=0, fill <= 0, so the next match needs len fresh bits.
    - If overlap=1, fill is kept and trailing bits may start the next match.
  - in_valid=0 edge: hist, fill and match_cnt hold; w <= 0.
  - Any edge without a match: w <= 0.
- Bits of hist above len are don't-care for matching.
- fill saturates at MAX_LEN; no wrap.
- Reset mid-sequence: everything returns to reset values immediately, including config. The block stays in IDLE until the next cfg_load.
- Back-to-back in_valid cycles are supported at full rate. Each valid bit yields at most one w pulse.

Test Plan:
- Reset, load len=7, pattern=7'b0111110, overlap=1; stream 0,1,1,1,1,1,0,1,1,1,1,1,0 with in_valid=1 -> w pulses after the 7th and the 13th bit (the shared 0 is reused); match_cnt=2.
- Same config with overlap=0, same stream -> single w pulse after the 7th bit; match_cnt=1.
- len=3, pattern=3'b101, overlap=1, stream 1,0,1,0,1 with in_valid toggling 1,0,1,... -> bits sampled only when in_valid=1; w after the 3rd and 5th sampled bit; no pulse in gap cycles.
- Load cfg_len=1, then cfg_len=MAX_LEN+1 -> cfg_err=1 each time; no w for any input; reload len=4 -> cfg_err=0.
- CNT_W=2, len=2, pattern=2'b11, overlap=1, stream eight 1s -> match_cnt saturates at 3; w continues pulsing.
- Mid-pattern (5 of 7 bits matched) drive rst=0 asynchronously -> w=0, match_cnt=0, cfg_err=0 immediately. After release, no match until cfg_load is reapplied.
